// File: rtl/seq_pkg.sv
// seq_pkg: shared states, constants and pattern-word helpers for the step sequencer
package seq_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT_DATA, HOLD} seq_state_t;
  localparam int MIN_TEMPO_DIV = 3;
  localparam int DEF_NOTE_WIDTH = 7;
  localparam int STEP_ACTIVE_BIT = DEF_NOTE_WIDTH;
  function automatic logic [DEF_NOTE_WIDTH:0] pack_step(input logic active, input logic [DEF_NOTE_WIDTH-1:0] note);
    return {active, note};
  endfunction
  function automatic logic step_active(input logic [DEF_NOTE_WIDTH:0] word);
    return word[STEP_ACTIVE_BIT];
  endfunction
  function automatic logic [DEF_NOTE_WIDTH-1:0] step_note(input logic [DEF_NOTE_WIDTH:0] word);
    return word[DEF_NOTE_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/step_sequencer_ctrl_step_timer.sv
// step_timer: tempo counter (clear/restart), clamped-period terminal count, gate window test on the next count
module step_timer #(
  parameter int DIV_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] tempo_div,
  input  logic [DIV_WIDTH-1:0] gate_len,
  output logic                 term,
  output logic                 gate_open
);
  import seq_pkg::*;
  logic [DIV_WIDTH-1:0] count, count_next, period;
  always_comb begin
    period = tempo_div < DIV_WIDTH'(MIN_TEMPO_DIV) ? DIV_WIDTH'(MIN_TEMPO_DIV) : tempo_div;
    count_next = clear ? '0 : count + 1'b1;
    term = count >= period - 1'b1;
    gate_open = count_next < gate_len;
  end
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else count <= count_next;
  end
endmodule

// File: rtl/step_sequencer_ctrl.sv
// step_sequencer_ctrl: fetches one pattern word per step, times steps, drives note/gate to the voice
module step_sequencer_ctrl #(
  parameter int STEP_BITS  = 4,
  parameter int DIV_WIDTH  = 24,
  parameter int NOTE_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  stop,
  input  logic [DIV_WIDTH-1:0]  tempo_div,
  input  logic [DIV_WIDTH-1:0]  gate_len,
  input  logic [STEP_BITS:0]    seq_length,
  output logic                  mem_rd_en,
  output logic [STEP_BITS-1:0]  mem_addr,
  input  logic [NOTE_WIDTH:0]   mem_rd_data,
  output logic [NOTE_WIDTH-1:0] note_out,
  output logic                  gate_out,
  output logic                  step_tick,
  output logic [STEP_BITS-1:0]  current_step,
  output logic                  running
);
  import seq_pkg::*;
  localparam logic [STEP_BITS:0] LEN_MAX = (STEP_BITS+1)'(2**STEP_BITS);
  seq_state_t state, state_next;
  logic [STEP_BITS-1:0] step, step_next, step_adv;
  logic [STEP_BITS:0] len_eff;
  logic active, active_next, gate_next, go_fetch, stop_now, latch, term, gate_open, clear;
  step_timer #(.DIV_WIDTH(DIV_WIDTH)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .tempo_div(tempo_div),
    .gate_len(gate_len),
    .term(term),
    .gate_open(gate_open)
  );
  always_comb begin
    stop_now = stop && state != IDLE;
    go_fetch = !stop && ((state == IDLE && play) || (state == HOLD && term));
    latch = state == WAIT_DATA && !stop;
    len_eff = seq_length == '0 ? (STEP_BITS+1)'(1) : seq_length > LEN_MAX ? LEN_MAX : seq_length;
    step_adv = ({1'b0, step} + 1'b1 >= len_eff) ? '0 : step + 1'b1;
    step_next = (stop_now || state == IDLE) ? '0 : go_fetch ? step_adv : step;
    state_next = stop_now ? IDLE : go_fetch ? FETCH : state == FETCH ? WAIT_DATA : state == WAIT_DATA ? HOLD : state;
    active_next = latch ? mem_rd_data[NOTE_WIDTH] : active;
    // FETCH/WAIT_DATA keep the previous gate so a legato note bridges into the next step
    gate_next = state_next != IDLE && (state_next == HOLD ? active_next : gate_out) && gate_open;
    clear = go_fetch || state_next == IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step <= '0;
      active <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr <= '0;
      note_out <= '0;
      gate_out <= 1'b0;
      step_tick <= 1'b0;
      current_step <= '0;
      running <= 1'b0;
    end else begin
      state <= state_next;
      step <= step_next;
      active <= active_next;
      mem_rd_en <= go_fetch;
      mem_addr <= go_fetch ? step_next : mem_addr;
      gate_out <= gate_next;
      step_tick <= latch;
      current_step <= latch ? step : current_step;
      note_out <= latch && mem_rd_data[NOTE_WIDTH] ? mem_rd_data[NOTE_WIDTH-1:0] : note_out;
      running <= state_next != IDLE;
    end
  end
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb_step_sequencer_ctrl: directed-vector bench for step_sequencer_ctrl with a 1-cycle-latency pattern RAM
module tb_step_sequencer_ctrl;
  import seq_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0;
  logic stop = 1'b0;
  logic [23:0] tempo_div = 24'd8;
  logic [23:0] gate_len = 24'd4;
  logic [4:0] seq_length = 5'd4;
  logic mem_rd_en;
  logic [3:0] mem_addr;
  logic [7:0] mem_rd_data = 8'h00;
  logic [6:0] note_out;
  logic gate_out, step_tick, running;
  logic [3:0] current_step;
  logic [7:0] ram [16];
  int vectors = 0;
  int errors = 0;
  step_sequencer_ctrl dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .stop(stop),
    .tempo_div(tempo_div),
    .gate_len(gate_len),
    .seq_length(seq_length),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .note_out(note_out),
    .gate_out(gate_out),
    .step_tick(step_tick),
    .current_step(current_step),
    .running(running)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_play();
    play = 1'b1;
    tick();
    play = 1'b0;
  endtask
  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("halt_running", running, 0);
    check("halt_gate", gate_out, 0);
    repeat (3) tick();
  endtask
  task automatic load(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3);
    ram[0] = w0;
    ram[1] = w1;
    ram[2] = w2;
    ram[3] = w3;
  endtask
  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_en"}, mem_rd_en, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_note"}, note_out, 0);
    check({tag, "_gate"}, gate_out, 0);
    check({tag, "_tick"}, step_tick, 0);
    check({tag, "_step"}, current_step, 0);
    check({tag, "_running"}, running, 0);
  endtask
  initial begin
    int exp_note [4];
    bit act [4];
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    repeat (2) tick();
    reset = 1'b0;
    check_idle_outputs("reset");
    tick();
    // basic playback: 8-cycle steps, 4-cycle gate window (counts 2,3 after WAIT_DATA)
    load(pack_step(1'b1, 7'd3), pack_step(1'b0, 7'd5), pack_step(1'b1, 7'd7), pack_step(1'b1, 7'd9));
    exp_note = '{3, 3, 7, 9};
    act = '{1'b1, 1'b0, 1'b1, 1'b1};
    pulse_play();
    for (int k = 0; k < 40; k++) begin
      check("basic_tick", step_tick, k % 8 == 2);
      check("basic_rd_en", mem_rd_en, k % 8 == 0);
      check("basic_gate", gate_out, act[(k / 8) % 4] && (k % 8 == 2 || k % 8 == 3));
      check("basic_running", running, 1);
      if (k % 8 == 0) check("basic_addr", mem_addr, (k / 8) % 4);
      if (k % 8 == 2) begin
        check("basic_step", current_step, (k / 8) % 4);
        check("basic_note", note_out, exp_note[(k / 8) % 4]);
      end
      tick();
    end
    halt();
    // legato: gate bridges into active steps, falls after WAIT_DATA of the inactive step 2
    load(8'h81, 8'h82, 8'h03, 8'h84);
    exp_note = '{1, 2, 2, 4};
    gate_len = 24'd20;
    pulse_play();
    for (int k = 0; k < 40; k++) begin
      check("legato_gate", gate_out, k >= 2 && !(k >= 18 && k <= 25));
      if (k % 8 == 2) check("legato_note", note_out, exp_note[(k / 8) % 4]);
      tick();
    end
    halt();
    // clamps: period 3, one-step pattern, gate_len 0 never gates
    load(8'h85, 8'h86, 8'h87, 8'h88);
    tempo_div = 24'd1;
    seq_length = 5'd0;
    gate_len = 24'd0;
    pulse_play();
    for (int k = 0; k < 15; k++) begin
      check("clamp_tick", step_tick, k % 3 == 2);
      check("clamp_gate", gate_out, 0);
      check("clamp_addr", mem_addr, 0);
      if (k % 3 == 2) check("clamp_step", current_step, 0);
      tick();
    end
    halt();
    // stop during step 1 WAIT_DATA while the legato gate is high
    load(pack_step(1'b1, 7'd3), pack_step(1'b1, 7'd5), pack_step(1'b1, 7'd7), pack_step(1'b1, 7'd9));
    tempo_div = 24'd8;
    seq_length = 5'd4;
    gate_len = 24'd20;
    pulse_play();
    repeat (9) tick();
    check("stopw_gate_before", gate_out, 1);
    check("stopw_step_before", current_step, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopw_gate", gate_out, 0);
    check("stopw_running", running, 0);
    check("stopw_tick", step_tick, 0);
    check("stopw_step_hold", current_step, 0);
    check("stopw_note_hold", note_out, 3);
    tick();
    check("stopw_idle_rd", mem_rd_en, 0);
    ram[0] = pack_step(1'b1, 7'd11);
    pulse_play();
    check("restart_rd_en", mem_rd_en, 1);
    check("restart_addr", mem_addr, 0);
    check("restart_running", running, 1);
    repeat (2) tick();
    check("restart_tick", step_tick, 1);
    check("restart_step", current_step, 0);
    check("restart_note", note_out, 11);
    halt();
    // play and stop together while idle: stop wins
    play = 1'b1;
    stop = 1'b1;
    tick();
    play = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("playstop_rd_en", mem_rd_en, 0);
      check("playstop_running", running, 0);
      tick();
    end
    // reset during HOLD with gate high
    gate_len = 24'd4;
    pulse_play();
    tick();
    ram[1] = pack_step(1'b1, 7'd13);
    tick();
    check("prereset_gate", gate_out, 1);
    check("prereset_note", note_out, 11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midreset");
    for (int k = 0; k < 6; k++) begin
      check("postreset_rd_en", mem_rd_en, 0);
      check("postreset_running", running, 0);
      tick();
    end
    pulse_play();
    check("resume_rd_en", mem_rd_en, 1);
    check("resume_addr", mem_addr, 0);
    repeat (2) tick();
    check("resume_tick", step_tick, 1);
    check("resume_step", current_step, 0);
    check("resume_note", note_out, 11);
    check("resume_gate", gate_out, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
